// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the reset PC, the bubble encoding and the IF/ID register layout.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          IMEM_ADDR_W = 6;
  localparam int          INSTR_W     = 32;
  localparam int          PC_W        = 32;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc4;
  } if_id_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: downstream control, imem port and IF/ID outputs.
// slave is the fetch stage itself; master is the surrounding pipeline/memory.
interface if_stage_if #(parameter int ADDR_W = 6);
  logic              stall_i;
  logic              flush_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic              if_id_valid_o;
  logic [31:0]       if_id_instr_o;
  logic [31:0]       if_id_pc_o;
  logic [31:0]       if_id_pc4_o;
  logic              misaligned_o;
  logic [31:0]       fetch_count_o;

  modport slave (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o,
           if_id_pc4_o, misaligned_o, fetch_count_o
  );

  modport master (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o,
           if_id_pc4_o, misaligned_o, fetch_count_o
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with squash > load > hold priority.
// A squash clears valid/instr to a NOP but keeps pc/pc4 for debug visibility.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_squash,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q.valid <= 1'b0;
      r_q.instr <= NOP_INSTR;
      r_q.pc    <= '0;
      r_q.pc4   <= '0;
    end else if (i_squash) begin
      r_q.valid <= 1'b0;
      r_q.instr <= NOP_INSTR;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux, fetch counter.
// The imem read is combinational, so the word at pc is captured as pc advances.
module if_stage #(
  parameter int          ADDR_W   = if_stage_pkg::IMEM_ADDR_W,
  parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.slave bus
);
  import if_stage_pkg::*;

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_fetch_count;
  logic            r_misaligned;

  logic            w_load;
  logic            w_squash;
  logic            w_count;
  logic [PC_W-1:0] w_pc4;
  logic [PC_W-1:0] w_pc_next;
  if_id_t          w_if_id_d;
  if_id_t          w_if_id_q;

  assign w_pc4    = r_pc + 32'd4;
  assign w_squash = bus.redirect_i | bus.flush_i;
  assign w_load   = ~bus.stall_i;
  assign w_count  = ~bus.redirect_i & ~bus.stall_i & ~bus.flush_i;

  // Priority: redirect beats stall beats sequential advance.
  always_comb begin
    w_pc_next = w_pc4;
    if (bus.redirect_i)   w_pc_next = word_align(bus.redirect_pc_i);
    else if (bus.stall_i) w_pc_next = r_pc;
  end

  always_comb begin
    w_if_id_d.valid = 1'b1;
    w_if_id_d.instr = bus.imem_rdata_i;
    w_if_id_d.pc    = r_pc;
    w_if_id_d.pc4   = w_pc4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_misaligned  <= bus.redirect_i & (|bus.redirect_pc_i[1:0]);
      if (w_count) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_squash (w_squash),
    .i_d      (w_if_id_d),
    .o_q      (w_if_id_q)
  );

  assign bus.imem_addr_o   = r_pc[ADDR_W-1:0];
  assign bus.if_id_valid_o = w_if_id_q.valid;
  assign bus.if_id_instr_o = w_if_id_q.instr;
  assign bus.if_id_pc_o    = w_if_id_q.pc;
  assign bus.if_id_pc4_o   = w_if_id_q.pc4;
  assign bus.misaligned_o  = r_misaligned;
  assign bus.fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 16-word imem image.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_if_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:15];

  if_stage_if #(.ADDR_W(6)) bus ();

  if_stage #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata_i = mem[bus.imem_addr_o[5:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] cnt);
    check({tag, ".valid"}, {31'b0, bus.if_id_valid_o}, {31'b0, v});
    check({tag, ".instr"}, bus.if_id_instr_o, ins);
    check({tag, ".pc"},    bus.if_id_pc_o, pc);
    check({tag, ".pc4"},   bus.if_id_pc4_o, pc4);
    check({tag, ".count"}, bus.fetch_count_o, cnt);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h20080017;
    mem[1] = 32'h2109002d;
    mem[2] = 32'hac090008;
    mem[7] = 32'h08000007;

    rst = 1'b1;
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    #3;
    chk_ifid("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("reset.addr", {26'b0, bus.imem_addr_o}, 32'h0);
    check("reset.mis", {31'b0, bus.misaligned_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: first two fetches
    tick();
    chk_ifid("t1e1", 1'b1, 32'h20080017, 32'h0, 32'h4, 32'd1);
    tick();
    chk_ifid("t1e2", 1'b1, 32'h2109002d, 32'h4, 32'h8, 32'd2);
    check("t1.addr", {26'b0, bus.imem_addr_o}, 32'h8);

    // 2: three-cycle stall
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2.addr", {26'b0, bus.imem_addr_o}, 32'h8);
      chk_ifid("t2.hold", 1'b1, 32'h2109002d, 32'h4, 32'h8, 32'd2);
    end
    bus.stall_i = 1'b0;
    tick();
    chk_ifid("t2.rel", 1'b1, 32'hac090008, 32'h8, 32'hC, 32'd3);
    check("t2.addr2", {26'b0, bus.imem_addr_o}, 32'hC);

    // 3: redirect wins over stall
    bus.stall_i       = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h1C;
    tick();
    check("t3.addr", {26'b0, bus.imem_addr_o}, 32'h1C);
    chk_ifid("t3.sq", 1'b0, 32'h0, 32'h8, 32'hC, 32'd3);
    check("t3.mis", {31'b0, bus.misaligned_o}, 32'h0);
    bus.stall_i    = 1'b0;
    bus.redirect_i = 1'b0;
    tick();
    chk_ifid("t3.tgt", 1'b1, 32'h08000007, 32'h1C, 32'h20, 32'd4);

    // 4: misaligned target
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0E;
    tick();
    check("t4.addr", {26'b0, bus.imem_addr_o}, 32'h0C);
    check("t4.mis1", {31'b0, bus.misaligned_o}, 32'h1);
    bus.redirect_i = 1'b0;
    tick();
    check("t4.mis0", {31'b0, bus.misaligned_o}, 32'h0);
    chk_ifid("t4.fetch", 1'b1, 32'h0, 32'h0C, 32'h10, 32'd5);

    // 5: imem address wrap, pc keeps counting
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h3C;
    tick();
    bus.redirect_i = 1'b0;
    check("t5.addr3c", {26'b0, bus.imem_addr_o}, 32'h3C);
    tick();
    check("t5.addr40", {26'b0, bus.imem_addr_o}, 32'h00);
    chk_ifid("t5.w15", 1'b1, 32'h0, 32'h3C, 32'h40, 32'd6);
    tick();
    chk_ifid("t5.wrap", 1'b1, 32'h20080017, 32'h40, 32'h44, 32'd7);

    // flush alone: bubble, pc advances, no count
    bus.flush_i = 1'b1;
    tick();
    chk_ifid("fl", 1'b0, 32'h0, 32'h40, 32'h44, 32'd7);
    check("fl.addr", {26'b0, bus.imem_addr_o}, 32'h08);

    // 6: stall & flush, then async reset between edges
    bus.stall_i = 1'b1;
    tick();
    check("t6.addr", {26'b0, bus.imem_addr_o}, 32'h08);
    check("t6.valid", {31'b0, bus.if_id_valid_o}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("t6.rvalid", {31'b0, bus.if_id_valid_o}, 32'h0);
    check("t6.rcount", bus.fetch_count_o, 32'h0);
    check("t6.raddr", {26'b0, bus.imem_addr_o}, 32'h0);
    check("t6.rpc", bus.if_id_pc_o, 32'h0);
    #1 rst = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    tick();
    chk_ifid("t6.post", 1'b1, 32'h20080017, 32'h0, 32'h4, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
